// File: rtl/rv_decode_stage_if.sv
// Fetch-to-execute bundle for the RV32I decode stage: fetch beat in, decoded beat out, flush.
// Latency: none (wires only).
// Backpressure: in_valid_i/in_ready_o on the fetch side, out_valid_o/out_ready_i on the execute side.
// Ports: flush_i; in_valid_i/in_ready_o/insn_i/pc_i; out_valid_o/out_ready_i/pc_o/opcode_o/
//        rd_o/rs1_o/rs2_o/funct3_o/alu_op_o/imm_o/illegal_o. slave = decode stage, master = its environment.
interface rv_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     insn_i;
  logic [XLEN-1:0] pc_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] pc_o;
  logic [6:0]      opcode_o;
  logic [4:0]      rd_o;
  logic [4:0]      rs1_o;
  logic [4:0]      rs2_o;
  logic [2:0]      funct3_o;
  logic [3:0]      alu_op_o;
  logic [XLEN-1:0] imm_o;
  logic            illegal_o;

  modport master (
    output flush_i, in_valid_i, insn_i, pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, pc_o, opcode_o, rd_o, rs1_o, rs2_o,
           funct3_o, alu_op_o, imm_o, illegal_o
  );

  modport slave (
    input  flush_i, in_valid_i, insn_i, pc_i, out_ready_i,
    output in_ready_o, out_valid_o, pc_o, opcode_o, rd_o, rs1_o, rs2_o,
           funct3_o, alu_op_o, imm_o, illegal_o
  );
endinterface

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage: decodes fields, ALU op, immediate and illegal flag between fetch and execute.
// Latency: 1 cycle from accept to out_valid_o.
// Backpressure: SKID_EN=1 two-entry skid, in_ready_o registered; SKID_EN=0 single register, in_ready_o = !out_valid_o | out_ready_i.
// Ports: clk_i, rst_i (async, active-high); bus (rv_decode_stage_if.slave) carries flush, fetch beat and decoded beat.
module rv_decode_stage #(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  rv_decode_stage_if.slave  bus
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_NONE = 4'd15;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } dec_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  // funct3 -> ALU op; alt selects the funct7[5] variant (SUB/SRA)
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic dec_t decode(input logic [31:0] insn, input logic [XLEN-1:0] pc);
    dec_t        d;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] imm32;
    logic [3:0]  op;
    logic        ok;
    f7    = insn[31:25];
    f3    = insn[14:12];
    imm32 = '0;
    op    = ALU_ADD;
    ok    = 1'b1;
    if (insn[1:0] != 2'b11) begin
      ok = 1'b0;
    end else begin
      case (insn[6:0])
        OPC_OP: begin
          if (f7 == 7'b0000000) op = alu_of(f3, 1'b0);
          else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) op = alu_of(f3, 1'b1);
          else ok = 1'b0;
        end
        OPC_OPIMM: begin
          imm32 = {{20{insn[31]}}, insn[31:20]};
          case (f3)
            3'b001: begin
              if (f7 == 7'b0000000) op = ALU_SLL;
              else ok = 1'b0;
            end
            3'b101: begin
              if (f7 == 7'b0000000) op = ALU_SRL;
              else if (f7 == 7'b0100000) op = ALU_SRA;
              else ok = 1'b0;
            end
            // ADDI has no SUB form, so funct7 is part of the immediate here
            default: op = alu_of(f3, 1'b0);
          endcase
        end
        OPC_LOAD, OPC_JALR: imm32 = {{20{insn[31]}}, insn[31:20]};
        OPC_STORE:          imm32 = {{20{insn[31]}}, insn[31:25], insn[11:7]};
        OPC_BRANCH: begin
          imm32 = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
          op    = ALU_SUB;
          if (f3 == 3'b010 || f3 == 3'b011) ok = 1'b0;
        end
        OPC_JAL:            imm32 = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
        OPC_LUI, OPC_AUIPC: imm32 = {insn[31:12], 12'b0};
        default:            ok = 1'b0;
      endcase
    end
    d.pc      = pc;
    d.opcode  = insn[6:0];
    d.rd      = insn[11:7];
    d.rs1     = insn[19:15];
    d.rs2     = insn[24:20];
    d.funct3  = f3;
    d.alu_op  = ok ? op : ALU_NONE;
    // signed cast so XLEN=64 sign-extends from bit 31
    d.imm     = ok ? XLEN'($signed(imm32)) : '0;
    d.illegal = ~ok;
    return d;
  endfunction

  state_t state_q, state_d;
  dec_t   out_q, skid_q, dec_in;
  logic   in_ready, out_valid, accept, consume;
  logic   load_out, load_skid, move_skid;

  assign dec_in  = decode(bus.insn_i, bus.pc_i);
  assign accept  = bus.in_valid_i & in_ready;
  assign consume = out_valid & bus.out_ready_i;

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    if (bus.flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) state_d = ONE;
        ONE: begin
          // without the skid, accept in ONE implies consume, so TWO is unreachable
          if (accept && !consume)      state_d = SKID_EN ? TWO : ONE;
          else if (!accept && consume) state_d = EMPTY;
        end
        TWO:     if (consume) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // outputs and datapath controls
  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = SKID_EN ? (state_q != TWO) : (state_q == EMPTY || bus.out_ready_i);
    load_out  = !bus.flush_i && accept && (state_q == EMPTY || (state_q == ONE && consume));
    load_skid = !bus.flush_i && SKID_EN && accept && state_q == ONE && !consume;
    move_skid = !bus.flush_i && state_q == TWO && consume;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q         <= '0;
      out_q.alu_op  <= ALU_NONE;
      skid_q        <= '0;
      skid_q.alu_op <= ALU_NONE;
    end else begin
      if (load_out)       out_q <= dec_in;
      else if (move_skid) out_q <= skid_q;
      if (load_skid)      skid_q <= dec_in;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.pc_o        = out_q.pc;
  assign bus.opcode_o    = out_q.opcode;
  assign bus.rd_o        = out_q.rd;
  assign bus.rs1_o       = out_q.rs1;
  assign bus.rs2_o       = out_q.rs2;
  assign bus.funct3_o    = out_q.funct3;
  assign bus.alu_op_o    = out_q.alu_op;
  assign bus.imm_o       = out_q.imm;
  assign bus.illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
module tb_rv_decode_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv_decode_stage_if #(.XLEN(32)) bus32 ();
  rv_decode_stage_if #(.XLEN(64)) bus64 ();

  rv_decode_stage #(.XLEN(32), .SKID_EN(1'b1)) dut (.clk_i(clk), .rst_i(rst), .bus(bus32.slave));
  rv_decode_stage #(.XLEN(64), .SKID_EN(1'b0)) dut64 (.clk_i(clk), .rst_i(rst), .bus(bus64.slave));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  // reference table: instruction, expected ALU op, immediate, illegal
  localparam int NV = 24;
  logic [31:0] t_insn [NV] = '{
    32'h002081B3, 32'h407302B3, 32'hFFF00093, 32'h4020D1B3, 32'h4030D093, 32'h0020B233,
    32'h0020F233, 32'hFFDFF0EF, 32'h12345137, 32'h80000297, 32'h0020A423, 32'hFE208CE3,
    32'hFFC12083, 32'h00000000, 32'h02000033, 32'h0020A063, 32'h40009093, 32'h002081B0,
    32'h00008067, 32'h002091B3, 32'h0020C1B3, 32'h0020E1B3, 32'h0020A1B3, 32'h0020D1B3};
  logic [3:0] t_alu [NV] = '{
    4'd0, 4'd1, 4'd0, 4'd7, 4'd7, 4'd4, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1,
    4'd0, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd0, 4'd2, 4'd5, 4'd8, 4'd3, 4'd6};
  logic [31:0] t_imm [NV] = '{
    32'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h00000403, 32'h0,
    32'h0, 32'hFFFFFFFC, 32'h12345000, 32'h80000000, 32'h00000008, 32'hFFFFFFF8,
    32'hFFFFFFFC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  logic t_ill [NV] = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  // scoreboard pop/compare on every consumed beat
  always @(negedge clk) begin
    if (!rst && !bus32.flush_i && bus32.out_valid_o && bus32.out_ready_i) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: got pc=%h alu=%0d with nothing expected", bus32.pc_o, bus32.alu_op_o);
      end else begin
        mon_e = sb.pop_front();
        if ({bus32.pc_o, bus32.opcode_o, bus32.rd_o, bus32.rs1_o, bus32.rs2_o, bus32.funct3_o,
             bus32.alu_op_o, bus32.imm_o, bus32.illegal_o} !==
            {mon_e.pc, mon_e.insn[6:0], mon_e.insn[11:7], mon_e.insn[19:15], mon_e.insn[24:20],
             mon_e.insn[14:12], mon_e.alu, mon_e.imm, mon_e.ill}) begin
          miscompares++;
          $display("FAIL sb_beat insn=%h: got pc=%h op=%h rd=%0d rs1=%0d rs2=%0d f3=%0d alu=%0d imm=%h ill=%b, want pc=%h alu=%0d imm=%h ill=%b",
                   mon_e.insn, bus32.pc_o, bus32.opcode_o, bus32.rd_o, bus32.rs1_o, bus32.rs2_o,
                   bus32.funct3_o, bus32.alu_op_o, bus32.imm_o, bus32.illegal_o,
                   mon_e.pc, mon_e.alu, mon_e.imm, mon_e.ill);
        end
      end
    end
  end

  // offer table entry idx until accepted; expectation pushed at the accepting edge
  task automatic send(input int idx);
    exp_t e;
    logic acc;
    bus32.in_valid_i = 1'b1;
    bus32.insn_i     = t_insn[idx];
    bus32.pc_i       = pc_ctr;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus32.in_ready_o;
      if (acc) begin
        e.pc = pc_ctr; e.insn = t_insn[idx]; e.alu = t_alu[idx]; e.imm = t_imm[idx]; e.ill = t_ill[idx];
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    if (!acc) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout insn=%h: in_ready stayed 0, want 1 within 50 cycles", t_insn[idx]);
    end
    bus32.in_valid_i = 1'b0;
    pc_ctr += 32'd4;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d beats still outstanding, want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus32.flush_i = 0; bus32.in_valid_i = 0; bus32.insn_i = '0; bus32.pc_i = '0; bus32.out_ready_i = 0;
    bus64.flush_i = 0; bus64.in_valid_i = 0; bus64.insn_i = '0; bus64.pc_i = '0; bus64.out_ready_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus32.out_valid_o, bus32.in_ready_o, bus32.alu_op_o, bus32.imm_o, bus32.pc_o, bus32.illegal_o, bus32.rd_o}
        !== {1'b1 ^ 1'b1, 1'b1, 4'd15, 32'h0, 32'h0, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL reset32: got v=%b rdy=%b alu=%0d imm=%h pc=%h ill=%b, want v=0 rdy=1 alu=15 imm=0 pc=0 ill=0",
               bus32.out_valid_o, bus32.in_ready_o, bus32.alu_op_o, bus32.imm_o, bus32.pc_o, bus32.illegal_o);
    end
    vectors++;
    if ({bus64.out_valid_o, bus64.in_ready_o, bus64.alu_op_o, bus64.imm_o} !== {1'b0, 1'b1, 4'd15, 64'h0}) begin
      miscompares++;
      $display("FAIL reset64: got v=%b rdy=%b alu=%0d imm=%h, want v=0 rdy=1 alu=15 imm=0",
               bus64.out_valid_o, bus64.in_ready_o, bus64.alu_op_o, bus64.imm_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_first_beat();
    bus32.out_ready_i = 1'b1;
    send(0);
    @(negedge clk);
    vectors++;
    if (bus32.out_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL latency: out_valid=%b one cycle after accept, want 1", bus32.out_valid_o);
    end
    drain();
  endtask

  task automatic test_alu();
    bus32.out_ready_i = 1'b1;
    for (int i = 1; i <= 6; i++) send(i);
    for (int i = 18; i < NV; i++) send(i);
    drain();
  endtask

  task automatic test_imm();
    bus32.out_ready_i = 1'b1;
    for (int i = 7; i <= 12; i++) send(i);
    drain();
  endtask

  task automatic test_illegal();
    bus32.out_ready_i = 1'b1;
    for (int i = 13; i <= 17; i++) send(i);
    send(0);
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] pc0;
    bus32.out_ready_i = 1'b0;
    pc0 = pc_ctr;
    send(7);
    send(8);
    bus32.in_valid_i = 1'b1; bus32.insn_i = t_insn[9]; bus32.pc_i = pc_ctr;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({bus32.out_valid_o, bus32.in_ready_o, bus32.pc_o, bus32.rd_o, bus32.imm_o}
          !== {1'b1, 1'b0, pc0, t_insn[7][11:7], t_imm[7]}) begin
        miscompares++;
        $display("FAIL hold_c%0d: got v=%b rdy=%b pc=%h rd=%0d imm=%h, want v=1 rdy=0 pc=%h rd=1 imm=%h",
                 c, bus32.out_valid_o, bus32.in_ready_o, bus32.pc_o, bus32.rd_o, bus32.imm_o, pc0, t_imm[7]);
      end
      @(posedge clk); #1;
    end
    bus32.out_ready_i = 1'b1;
    send(9);
    drain();
  endtask

  task automatic test_back_to_back();
    logic done;
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 40; n++) send(int'($urandom_range(0, NV - 1)));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus32.out_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    bus32.out_ready_i = 1'b1;
    drain();
  endtask

  task automatic test_flush();
    // flush while in TWO with a beat offered
    bus32.out_ready_i = 1'b0;
    send(1);
    send(2);
    bus32.flush_i = 1'b1; bus32.in_valid_i = 1'b1; bus32.insn_i = t_insn[3]; bus32.pc_i = pc_ctr;
    @(posedge clk); #1;
    bus32.flush_i = 1'b0; bus32.in_valid_i = 1'b0;
    sb.delete();
    @(negedge clk);
    vectors++;
    if ({bus32.out_valid_o, bus32.in_ready_o} !== 2'b01) begin
      miscompares++;
      $display("FAIL flush_two: got v=%b rdy=%b, want v=0 rdy=1", bus32.out_valid_o, bus32.in_ready_o);
    end
    // flush while in ONE with a concurrent accept that must be discarded
    @(posedge clk); #1;
    send(4);
    bus32.flush_i = 1'b1; bus32.in_valid_i = 1'b1; bus32.insn_i = t_insn[5]; bus32.pc_i = pc_ctr;
    @(negedge clk);
    vectors++;
    if (bus32.in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_one_rdy: got rdy=%b, want 1", bus32.in_ready_o);
    end
    @(posedge clk); #1;
    bus32.flush_i = 1'b0; bus32.in_valid_i = 1'b0;
    sb.delete();
    @(negedge clk);
    vectors++;
    if ({bus32.out_valid_o, bus32.in_ready_o} !== 2'b01) begin
      miscompares++;
      $display("FAIL flush_one: got v=%b rdy=%b, want v=0 rdy=1", bus32.out_valid_o, bus32.in_ready_o);
    end
    @(posedge clk); #1;
    bus32.out_ready_i = 1'b1;
    send(6);
    drain();
  endtask

  task automatic test_reset_midstream();
    bus32.out_ready_i = 1'b0;
    send(10);
    send(11);
    rst = 1'b1;
    #1;
    vectors++;
    if (bus32.out_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async: got v=%b right after reset asserted, want 0", bus32.out_valid_o);
    end
    sb.delete();
    @(negedge clk);
    vectors++;
    if ({bus32.out_valid_o, bus32.in_ready_o, bus32.alu_op_o} !== {1'b0, 1'b1, 4'd15}) begin
      miscompares++;
      $display("FAIL rst_mid: got v=%b rdy=%b alu=%0d, want v=0 rdy=1 alu=15",
               bus32.out_valid_o, bus32.in_ready_o, bus32.alu_op_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus32.out_ready_i = 1'b1;
    send(12);
    drain();
  endtask

  task automatic test_xlen64_noskid();
    int          idx [4] = '{7, 8, 9, 2};
    logic [63:0] e64 [4] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_1234_5000,
                             64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] pc2;
    bus64.out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus64.in_valid_i = 1'b1; bus64.insn_i = t_insn[idx[k]]; bus64.pc_i = 64'h8000_0000_0000_0000 + 64'(k * 4);
      @(posedge clk); #1;
      bus64.in_valid_i = 1'b0;
      @(negedge clk);
      vectors++;
      if ({bus64.out_valid_o, bus64.imm_o, bus64.alu_op_o, bus64.illegal_o} !== {1'b1, e64[k], 4'd0, 1'b0}) begin
        miscompares++;
        $display("FAIL imm64 insn=%h: got v=%b imm=%h alu=%0d ill=%b, want v=1 imm=%h alu=0 ill=0",
                 t_insn[idx[k]], bus64.out_valid_o, bus64.imm_o, bus64.alu_op_o, bus64.illegal_o, e64[k]);
      end
      @(posedge clk); #1;
    end
    // combinational ready: follows out_ready while a beat is held
    bus64.out_ready_i = 1'b0;
    bus64.in_valid_i = 1'b1; bus64.insn_i = t_insn[0]; bus64.pc_i = 64'h100;
    @(posedge clk); #1;
    pc2 = 64'h104;
    bus64.insn_i = t_insn[1]; bus64.pc_i = pc2;
    @(negedge clk);
    vectors++;
    if ({bus64.out_valid_o, bus64.in_ready_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL noskid_stall: got v=%b rdy=%b, want v=1 rdy=0", bus64.out_valid_o, bus64.in_ready_o);
    end
    bus64.out_ready_i = 1'b1;
    #1;
    vectors++;
    if (bus64.in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL noskid_comb_rdy: got rdy=%b, want 1", bus64.in_ready_o);
    end
    @(posedge clk); #1;
    bus64.in_valid_i = 1'b0;
    bus64.out_ready_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus64.out_valid_o, bus64.pc_o, bus64.alu_op_o} !== {1'b1, pc2, 4'd1}) begin
      miscompares++;
      $display("FAIL noskid_next: got v=%b pc=%h alu=%0d, want v=1 pc=%h alu=1",
               bus64.out_valid_o, bus64.pc_o, bus64.alu_op_o, pc2);
    end
    @(posedge clk); #1;
    bus64.out_ready_i = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_first_beat();
    test_alu();
    test_imm();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    test_xlen64_noskid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
